// File: rtl/uart_pkg.sv
// Shared UART definitions: frame opcodes (also used by the host-side transmit framer)
// and the frame-decoder FSM state type.
package uart_pkg;

    localparam logic [7:0] UART_OP_RD = 8'hA0;
    localparam logic [7:0] UART_OP_WR = 8'hA1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_ISSUE
    } dec_state_t;

    function automatic logic is_opcode(input logic [7:0] b);
        return (b == UART_OP_RD) || (b == UART_OP_WR);
    endfunction

endpackage

// File: rtl/uart_rx_frame_decoder_if.sv
// Receiver-side byte input, bus-side request handshake and error pulses of the frame decoder.
// master = decoder, slave = the receiver/bus environment around it.
interface uart_rx_frame_decoder_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 8
);
    logic                  rx_ready;
    logic [7:0]            rx_data;
    logic                  req_valid;
    logic                  req_write;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic                  req_ready;
    logic                  err_cmd;
    logic                  err_overrun;
    logic                  err_timeout;

    modport master (
        input  rx_ready, rx_data, req_ready,
        output req_valid, req_write, req_addr, req_wdata,
        output err_cmd, err_overrun, err_timeout
    );

    modport slave (
        output rx_ready, rx_data, req_ready,
        input  req_valid, req_write, req_addr, req_wdata,
        input  err_cmd, err_overrun, err_timeout
    );
endinterface

// File: rtl/uart_edge_det.sv
// Registered rising-edge detector: one-cycle strobe on the first clock a level goes high.
// Also suitable for the transmitter's done level.
module uart_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic i_level,
    output logic o_rise
);
    logic r_level_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_level_q <= 1'b0;
        else     r_level_q <= i_level;
    end

    assign o_rise = i_level & ~r_level_q;
endmodule

// File: rtl/uart_rx_frame_decoder.sv
// Assembles opcode/address/data byte frames from the UART receiver into bus read/write requests.
// Optional inter-byte timeout is built when UART_RX_DEC_TIMEOUT_EN is defined.
module uart_rx_frame_decoder
    import uart_pkg::*;
#(
    parameter int ADDR_WIDTH   = 16,
    parameter int DATA_WIDTH   = 8,
    parameter int TIMEOUT_CLKS = 4096
) (
    input  logic clk,
    input  logic rst,
    uart_rx_frame_decoder_if.master bus
);
    localparam int AB   = ADDR_WIDTH / 8;
    localparam int DB   = DATA_WIDTH / 8;
    localparam int MAXB = (AB > DB) ? AB : DB;
    localparam int CW   = $clog2(MAXB + 1);
    localparam logic [CW-1:0] AB_LAST = CW'(AB - 1);
    localparam logic [CW-1:0] DB_LAST = CW'(DB - 1);

    logic                  w_strobe;
    logic                  w_decode;
    logic                  w_timeout;
    dec_state_t            r_state,   w_state_next;
    logic [CW-1:0]         r_cnt,     w_cnt_next;
    logic [ADDR_WIDTH-1:0] r_addr,    w_addr_next;
    logic [DATA_WIDTH-1:0] r_wdata,   w_wdata_next;
    logic                  r_write,   w_write_next;
    logic                  r_err_cmd, w_err_cmd_next;
    logic                  r_err_ovr, w_err_ovr_next;
    logic                  r_err_to;

    uart_edge_det u_edge_det (
        .clk     (clk),
        .rst     (rst),
        .i_level (bus.rx_ready),
        .o_rise  (w_strobe)
    );

`ifdef UART_RX_DEC_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CLKS);
    logic [TW-1:0] r_tcnt;

    // Idle-gap counter only runs while a frame is partially assembled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_tcnt <= '0;
        else if (w_strobe || !((r_state == ST_ADDR) || (r_state == ST_DATA)))
            r_tcnt <= '0;
        else
            r_tcnt <= r_tcnt + 1'b1;
    end

    assign w_timeout = ((r_state == ST_ADDR) || (r_state == ST_DATA)) && !w_strobe
                       && (r_tcnt == TW'(TIMEOUT_CLKS - 1));
`else
    assign w_timeout = 1'b0;
`endif

    // A byte that arrives on the handshake edge belongs to the next frame, so it is decoded as an opcode.
    assign w_decode = w_strobe &&
                      ((r_state == ST_IDLE) || ((r_state == ST_ISSUE) && bus.req_ready));

    always_comb begin
        w_state_next   = r_state;
        w_cnt_next     = r_cnt;
        w_addr_next    = r_addr;
        w_wdata_next   = r_wdata;
        w_write_next   = r_write;
        w_err_cmd_next = 1'b0;
        w_err_ovr_next = 1'b0;

        case (r_state)
            ST_ADDR: begin
                if (w_strobe) begin
                    w_addr_next = (r_addr << 8) | ADDR_WIDTH'(bus.rx_data);
                    if (r_cnt == AB_LAST) begin
                        w_cnt_next = '0;
                        if (r_write) begin
                            w_state_next = ST_DATA;
                        end else begin
                            w_state_next = ST_ISSUE;
                            w_wdata_next = '0;
                        end
                    end else begin
                        w_cnt_next = r_cnt + 1'b1;
                    end
                end else if (w_timeout) begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_DATA: begin
                if (w_strobe) begin
                    w_wdata_next = (r_wdata << 8) | DATA_WIDTH'(bus.rx_data);
                    if (r_cnt == DB_LAST) begin
                        w_cnt_next   = '0;
                        w_state_next = ST_ISSUE;
                    end else begin
                        w_cnt_next = r_cnt + 1'b1;
                    end
                end else if (w_timeout) begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (bus.req_ready)
                    w_state_next = ST_IDLE;
                else if (w_strobe)
                    w_err_ovr_next = 1'b1;
            end
            default: ;
        endcase

        if (w_decode) begin
            if (is_opcode(bus.rx_data)) begin
                w_write_next = (bus.rx_data == UART_OP_WR);
                w_cnt_next   = '0;
                w_state_next = ST_ADDR;
            end else begin
                w_err_cmd_next = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_write   <= 1'b0;
            r_err_cmd <= 1'b0;
            r_err_ovr <= 1'b0;
            r_err_to  <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_cnt     <= w_cnt_next;
            r_addr    <= w_addr_next;
            r_wdata   <= w_wdata_next;
            r_write   <= w_write_next;
            r_err_cmd <= w_err_cmd_next;
            r_err_ovr <= w_err_ovr_next;
            r_err_to  <= w_timeout;
        end
    end

    assign bus.req_valid   = (r_state == ST_ISSUE);
    assign bus.req_write   = r_write;
    assign bus.req_addr    = r_addr;
    assign bus.req_wdata   = r_wdata;
    assign bus.err_cmd     = r_err_cmd;
    assign bus.err_overrun = r_err_ovr;
    assign bus.err_timeout = r_err_to;
endmodule

// File: tb/tb_uart_rx_frame_decoder.sv
// Scoreboard bench for uart_rx_frame_decoder: expected requests are queued as frames are sent
// and checked when the bus side accepts them; error pulses are counted and checked per scenario.
module tb_uart_rx_frame_decoder;
    import uart_pkg::*;

    localparam int AW = 16;
    localparam int DW = 8;
`ifdef UART_RX_DEC_TIMEOUT_EN
    localparam int TO = 64;
`else
    localparam int TO = 4096;
`endif

    typedef struct {
        logic          write;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } req_t;

    logic clk = 1'b0;
    logic rst;
    req_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   nCmd = 0;
    int   nOvr = 0;
    int   nTo  = 0;

    always #5 clk = ~clk;

    uart_rx_frame_decoder_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    uart_rx_frame_decoder #(
        .ADDR_WIDTH   (AW),
        .DATA_WIDTH   (DW),
        .TIMEOUT_CLKS (TO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Inputs change on the falling edge; this samples 1 ns later, i.e. what the next rising edge sees.
    always begin : monitor
        req_t e;
        @(negedge clk);
        #1;
        if (!rst) begin
            if (bus.err_cmd)     nCmd++;
            if (bus.err_overrun) nOvr++;
            if (bus.err_timeout) nTo++;
            if (bus.req_valid && bus.req_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("[TB] FAIL unexpected_request got w=%0b addr=%h wdata=%h, expected none",
                             bus.req_write, bus.req_addr, bus.req_wdata);
                end else begin
                    e = sb.pop_front();
                    if (bus.req_write !== e.write || bus.req_addr !== e.addr || bus.req_wdata !== e.wdata) begin
                        failures++;
                        $display("[TB] FAIL request got w=%0b addr=%h wdata=%h, expected w=%0b addr=%h wdata=%h",
                                 bus.req_write, bus.req_addr, bus.req_wdata, e.write, e.addr, e.wdata);
                    end
                end
            end
        end
    end

    task automatic applyStimulus(input logic [7:0] b);
        @(negedge clk);
        bus.rx_data  = b;
        bus.rx_ready = 1'b1;
        repeat (3) @(negedge clk);
        bus.rx_ready = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        #1;
        checks++;
        if (bus.req_valid !== 1'b0 || bus.req_write !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_ctrl got valid=%b write=%b, expected 0 0", bus.req_valid, bus.req_write);
        end
        checks++;
        if (bus.req_addr !== 16'h0000 || bus.req_wdata !== 8'h00) begin
            failures++;
            $display("[TB] FAIL reset_data got addr=%h wdata=%h, expected 0000 00", bus.req_addr, bus.req_wdata);
        end
        checks++;
        if ({bus.err_cmd, bus.err_overrun, bus.err_timeout} !== 3'b000) begin
            failures++;
            $display("[TB] FAIL reset_err got %b, expected 000", {bus.err_cmd, bus.err_overrun, bus.err_timeout});
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_read();
        sb.push_back('{1'b0, 16'h1234, 8'h00});
        applyStimulus(UART_OP_RD);
        applyStimulus(8'h12);
        @(negedge clk);
        bus.rx_data  = 8'h34;
        bus.rx_ready = 1'b1;
        #1;
        checks++;
        if (bus.req_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL read_early_valid got %b, expected 0", bus.req_valid);
        end
        @(posedge clk);
        #1;
        checks++;
        if (bus.req_valid !== 1'b1) begin
            failures++;
            $display("[TB] FAIL read_valid_rise got %b, expected 1", bus.req_valid);
        end
        @(posedge clk);
        #1;
        checks++;
        if (bus.req_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL read_valid_drop got %b, expected 0", bus.req_valid);
        end
        @(negedge clk);
        bus.rx_ready = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("[TB] FAIL read_drain got %0d pending, expected 0", sb.size());
        end
    endtask

    task automatic test_write_stall();
        int bad = 0;
        @(negedge clk);
        bus.req_ready = 1'b0;
        sb.push_back('{1'b1, 16'hBEEF, 8'h5C});
        applyStimulus(UART_OP_WR);
        applyStimulus(8'hBE);
        applyStimulus(8'hEF);
        applyStimulus(8'h5C);
        repeat (20) begin
            @(negedge clk);
            #1;
            if (bus.req_valid !== 1'b1 || bus.req_write !== 1'b1 ||
                bus.req_addr !== 16'hBEEF || bus.req_wdata !== 8'h5C) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("[TB] FAIL write_hold got %0d unstable cycles, expected 0", bad);
        end
        @(negedge clk);
        bus.req_ready = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (bus.req_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL write_valid_drop got %b, expected 0", bus.req_valid);
        end
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("[TB] FAIL write_drain got %0d pending, expected 0", sb.size());
        end
    endtask

    task automatic test_bad_opcode();
        int c0 = nCmd;
        sb.push_back('{1'b0, 16'h0001, 8'h00});
        applyStimulus(8'h7F);
        checks++;
        if (nCmd != c0 + 1) begin
            failures++;
            $display("[TB] FAIL err_cmd_pulse got %0d pulses, expected 1", nCmd - c0);
        end
        applyStimulus(UART_OP_RD);
        applyStimulus(8'h00);
        applyStimulus(8'h01);
        for (int i = 0; i < 40 && sb.size() != 0; i++) begin
            @(negedge clk);
            #2;
        end
        checks++;
        if (sb.size() != 0 || nCmd != c0 + 1) begin
            failures++;
            $display("[TB] FAIL bad_opcode_drain got pending=%0d cmd_pulses=%0d, expected 0 1", sb.size(), nCmd - c0);
        end
    endtask

    task automatic test_overrun();
        int o0;
        @(negedge clk);
        bus.req_ready = 1'b0;
        sb.push_back('{1'b0, 16'h4242, 8'h00});
        applyStimulus(UART_OP_RD);
        applyStimulus(8'h42);
        applyStimulus(8'h42);
        o0 = nOvr;
        applyStimulus(8'h55);
        checks++;
        if (nOvr != o0 + 1) begin
            failures++;
            $display("[TB] FAIL overrun_pulse got %0d pulses, expected 1", nOvr - o0);
        end
        #1;
        checks++;
        if (bus.req_valid !== 1'b1 || bus.req_addr !== 16'h4242 || bus.req_wdata !== 8'h00) begin
            failures++;
            $display("[TB] FAIL overrun_hold got valid=%b addr=%h wdata=%h, expected 1 4242 00",
                     bus.req_valid, bus.req_addr, bus.req_wdata);
        end
        @(negedge clk);
        bus.req_ready = 1'b1;
        for (int i = 0; i < 40 && sb.size() != 0; i++) begin
            @(negedge clk);
            #2;
        end
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("[TB] FAIL overrun_drain got %0d pending, expected 0", sb.size());
        end
    endtask

    task automatic test_handshake_opcode();
        int o0;
        int c0;
        @(negedge clk);
        bus.req_ready = 1'b0;
        sb.push_back('{1'b0, 16'h0005, 8'h00});
        sb.push_back('{1'b0, 16'h0006, 8'h00});
        applyStimulus(UART_OP_RD);
        applyStimulus(8'h00);
        applyStimulus(8'h05);
        o0 = nOvr;
        c0 = nCmd;
        @(negedge clk);
        bus.rx_data   = UART_OP_RD;
        bus.rx_ready  = 1'b1;
        bus.req_ready = 1'b1;
        repeat (3) @(negedge clk);
        bus.rx_ready = 1'b0;
        repeat (2) @(negedge clk);
        applyStimulus(8'h00);
        applyStimulus(8'h06);
        for (int i = 0; i < 40 && sb.size() != 0; i++) begin
            @(negedge clk);
            #2;
        end
        checks++;
        if (sb.size() != 0 || nOvr != o0 || nCmd != c0) begin
            failures++;
            $display("[TB] FAIL handshake_opcode got pending=%0d ovr=%0d cmd=%0d, expected 0 0 0",
                     sb.size(), nOvr - o0, nCmd - c0);
        end
    endtask

    task automatic test_back_to_back();
        sb.push_back('{1'b1, 16'h0102, 8'h33});
        sb.push_back('{1'b0, 16'hABCD, 8'h00});
        applyStimulus(UART_OP_WR);
        applyStimulus(8'h01);
        applyStimulus(8'h02);
        applyStimulus(8'h33);
        applyStimulus(UART_OP_RD);
        applyStimulus(8'hAB);
        applyStimulus(8'hCD);
        for (int i = 0; i < 40 && sb.size() != 0; i++) begin
            @(negedge clk);
            #2;
        end
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("[TB] FAIL back_to_back got %0d pending, expected 0", sb.size());
        end
    endtask

    task automatic test_timeout();
        int t0 = nTo;
        applyStimulus(UART_OP_WR);
        applyStimulus(8'h12);
        repeat (100) @(negedge clk);
        #1;
`ifdef UART_RX_DEC_TIMEOUT_EN
        checks++;
        if (nTo != t0 + 1 || bus.req_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL timeout_pulse got pulses=%0d valid=%b, expected 1 0", nTo - t0, bus.req_valid);
        end
        sb.push_back('{1'b0, 16'h0002, 8'h00});
        applyStimulus(UART_OP_RD);
        applyStimulus(8'h00);
        applyStimulus(8'h02);
`else
        checks++;
        if (nTo != t0 || bus.req_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL no_timeout got pulses=%0d valid=%b, expected 0 0", nTo - t0, bus.req_valid);
        end
        sb.push_back('{1'b1, 16'h1234, 8'h77});
        applyStimulus(8'h34);
        applyStimulus(8'h77);
`endif
        for (int i = 0; i < 40 && sb.size() != 0; i++) begin
            @(negedge clk);
            #2;
        end
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("[TB] FAIL timeout_resume got %0d pending, expected 0", sb.size());
        end
    endtask

    task automatic test_reset_midframe();
        applyStimulus(UART_OP_WR);
        applyStimulus(8'hBE);
        applyStimulus(8'hEF);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (bus.req_valid !== 1'b0 || bus.req_write !== 1'b0 || bus.req_addr !== 16'h0000 || bus.req_wdata !== 8'h00) begin
            failures++;
            $display("[TB] FAIL reset_midframe got valid=%b write=%b addr=%h wdata=%h, expected all 0",
                     bus.req_valid, bus.req_write, bus.req_addr, bus.req_wdata);
        end
        bus.rx_data  = UART_OP_RD;
        bus.rx_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        sb.push_back('{1'b0, 16'h0007, 8'h00});
        repeat (2) @(negedge clk);
        bus.rx_ready = 1'b0;
        repeat (2) @(negedge clk);
        applyStimulus(8'h00);
        applyStimulus(8'h07);
        sb.push_back('{1'b1, 16'h0F0F, 8'hA5});
        applyStimulus(UART_OP_WR);
        applyStimulus(8'h0F);
        applyStimulus(8'h0F);
        applyStimulus(8'hA5);
        for (int i = 0; i < 40 && sb.size() != 0; i++) begin
            @(negedge clk);
            #2;
        end
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("[TB] FAIL reset_recover got %0d pending, expected 0", sb.size());
        end
    endtask

    initial begin
        rst           = 1'b1;
        bus.rx_ready  = 1'b0;
        bus.rx_data   = 8'h00;
        bus.req_ready = 1'b1;
        test_reset();
        test_read();
        test_write_stall();
        test_bad_opcode();
        test_overrun();
        test_handshake_opcode();
        test_back_to_back();
        test_timeout();
        test_reset_midframe();
        repeat (5) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("[TB] FAIL final_queue got %0d pending, expected 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
